riscv_aes_writeback_unit: RTL and testbench
===========================================

// Module: riscv_aes_writeback_unit
// PURPOSE
//  Store path of the RISC-V AES accelerator. Captures the 128-bit AES result when the
//  AES core finishes. Writes the result to data memory as NUM_WORDS consecutive 32-bit
//  stores starting at the writeback address held in the AES register file.
//  Sits between the AES core and the core's data-memory port (req/gnt/rvalid protocol).
// PARAMETERS
//  DATA_WIDTH  32  width of one memory word / store
//  NUM_WORDS   4   words per AES block (NUM_WORDS*DATA_WIDTH = result width)
//  ADDR_WIDTH  32  memory address width
// PORTS
//  clk            in   1            clock, all state on rising edge
//  rst            in   1            reset, asynchronous, active-high
//  aes_done_i     in   1            1-cycle pulse: aes_result_i valid this cycle
//  aes_result_i   in   NUM_WORDS*DATA_WIDTH  AES result, word k = bits [32k+31:32k]
//  wb_addr_i      in   ADDR_WIDTH   writeback base address, sampled with aes_done_i
//  data_req_o     out  1            store request
//  data_addr_o    out  ADDR_WIDTH   store address, word aligned
//  data_we_o      out  1            write enable, 1 whenever data_req_o=1
//  data_be_o      out  4            byte enables, 4'hF whenever data_req_o=1
//  data_wdata_o   out  DATA_WIDTH   store data
//  data_gnt_i     in   1            memory accepted request this cycle
//  data_rvalid_i  in   1            store response
//  data_err_i     in   1            error flag, qualified by data_rvalid_i
//  wb_busy_o      out  1            writeback in progress; core must stall AES issue
//  wb_done_o      out  1            1-cycle pulse: last response received
//  wb_err_o       out  1            valid with wb_done_o: any response of the block had err
//  wb_overrun_o   out  1            1-cycle pulse: aes_done_i dropped while busy
// BEHAVIOUR
//  Reset: state IDLE, word counter 0, buffer/base 0, error accumulator 0;
//   all outputs 0, including data_be_o.
//  FSM IDLE -> REQ -> WAIT -> (REQ | DONE) -> IDLE.
//  IDLE: on aes_done_i, latch aes_result_i and {wb_addr_i[31:2],2'b00}; clear counter
//   and error accumulator; go to REQ. wb_addr_i[1:0] ignored.
//  REQ: data_req_o=1, addr=base+4*cnt, wdata=buffer word cnt.
//   Hold addr/wdata/req stable until data_gnt_i=1. On gnt go to WAIT; req drops next cycle.
//  WAIT: exactly one outstanding store. On data_rvalid_i, OR data_err_i into the accumulator.
//   If cnt==NUM_WORDS-1 go to DONE, else cnt++ and go to REQ.
//   rvalid is never accepted in the same cycle as its gnt; minimum 1 cycle gnt->rvalid.
//  DONE: wb_done_o=1 and wb_err_o=accumulator for one cycle; go to IDLE.
//  wb_busy_o=1 in REQ, WAIT, DONE; wb_busy_o=0 only in IDLE.
//  Minimum latency, gnt same cycle as req and rvalid next cycle: aes_done_i at cycle 0
//   gives wb_done_o at cycle 2*NUM_WORDS+1.
//  Address arithmetic is modulo 2^ADDR_WIDTH; 32'hFFFF_FFF8 base wraps to 0, 4.
//  Error does not abort: all NUM_WORDS stores are issued.
//  aes_done_i while busy: ignored, buffer unchanged, wb_overrun_o pulses the same cycle.
//  aes_done_i in the DONE cycle also counts as an overrun.
//  Stray data_rvalid_i in IDLE/REQ and stray data_gnt_i outside REQ: ignored.
//  Reset mid-operation: immediate return to IDLE. data_req_o drops asynchronously.
//   No wb_done_o is generated.
// TESTING
//  1. Base 0x1000, result 128'h33333333_22222222_11111111_00000000, gnt=req, rvalid+1
//     -> stores 0x1000=00000000, 0x1004=11111111, 0x1008=22222222, 0x100C=33333333;
//     wb_done_o at cycle 9, wb_err_o=0.
//  2. gnt delayed 3 cycles per store, rvalid delayed 2 cycles
//     -> addr/wdata/req stable while ungranted, never two outstanding, 4 stores in order.
//  3. Base 0x2003, err asserted on 3rd response
//     -> stores at 0x2000..0x200C, all 4 issued, wb_err_o=1 with wb_done_o.
//  4. Second aes_done_i with different data during store 2
//     -> wb_overrun_o pulse, original data completes, no extra stores.
//  5. Base 0xFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
//  6. rst asserted while in WAIT, then new aes_done_i
//     -> outputs 0 immediately, no wb_done_o, new block written from word 0.

Source files
------------

// File: rtl/riscv_aes_writeback_unit_if.sv
// riscv_aes_writeback_unit_if: data-memory store port with req/gnt/rvalid handshake
interface riscv_aes_writeback_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  data_req;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic                  data_we;
    logic [3:0]            data_be;
    logic [DATA_WIDTH-1:0] data_wdata;
    logic                  data_gnt;
    logic                  data_rvalid;
    logic                  data_err;
    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_err
    );
    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_err
    );
endinterface

// File: rtl/riscv_aes_writeback_unit.sv
// riscv_aes_writeback_unit: stores a finished AES block to memory as consecutive word writes
module riscv_aes_writeback_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            aes_done_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] aes_result_i,
    input  logic [ADDR_WIDTH-1:0]           wb_addr_i,
    riscv_aes_writeback_unit_if.master      mem,
    output logic                            wb_busy_o,
    output logic                            wb_done_o,
    output logic                            wb_err_o,
    output logic                            wb_overrun_o
);
    localparam int CW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t                               state;
    logic [CW-1:0]                        cnt_q;
    logic [CW-1:0]                        nxt;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] res_q;
    logic [ADDR_WIDTH-1:0]                base_q;
    logic [ADDR_WIDTH-1:0]                base_in;
    logic                                 err_q;
    assign nxt          = cnt_q + CW'(1);
    assign base_in      = wb_addr_i & ~ADDR_WIDTH'(3);
    assign wb_busy_o    = state != IDLE;
    assign wb_overrun_o = aes_done_i && state != IDLE;
    assign mem.data_we  = mem.data_req;
    assign mem.data_be  = {4{mem.data_req}};
    // Writeback FSM: one store outstanding at a time, bus outputs registered and held until granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt_q          <= '0;
            res_q          <= '0;
            base_q         <= '0;
            err_q          <= 1'b0;
            mem.data_req   <= 1'b0;
            mem.data_addr  <= '0;
            mem.data_wdata <= '0;
            wb_done_o      <= 1'b0;
            wb_err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (aes_done_i) begin
                    state          <= REQ;
                    res_q          <= aes_result_i;
                    base_q         <= base_in;
                    cnt_q          <= '0;
                    err_q          <= 1'b0;
                    mem.data_req   <= 1'b1;
                    mem.data_addr  <= base_in;
                    mem.data_wdata <= aes_result_i[DATA_WIDTH-1:0];
                end
                REQ: if (mem.data_gnt) begin
                    state        <= WAIT;
                    mem.data_req <= 1'b0;
                end
                WAIT: if (mem.data_rvalid) begin
                    err_q <= err_q | mem.data_err;
                    if (cnt_q == CW'(NUM_WORDS - 1)) begin
                        state     <= DONE;
                        wb_done_o <= 1'b1;
                        wb_err_o  <= err_q | mem.data_err;
                    end else begin
                        state          <= REQ;
                        cnt_q          <= nxt;
                        mem.data_req   <= 1'b1;
                        mem.data_addr  <= base_q + ADDR_WIDTH'({nxt, 2'b00});
                        mem.data_wdata <= res_q[nxt];
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    wb_done_o <= 1'b0;
                    wb_err_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_aes_writeback_unit.sv
// tb_riscv_aes_writeback_unit: randomized memory responder checked against a store scoreboard
module tb_riscv_aes_writeback_unit;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         aes_done = 1'b0;
    logic [127:0] aes_result = '0;
    logic [31:0]  wb_addr = '0;
    logic         wb_busy, wb_done, wb_err, wb_overrun;
    int           n_tests = 0;
    int           n_fail = 0;

    riscv_aes_writeback_unit_if mem();

    riscv_aes_writeback_unit dut (
        .clk(clk), .rst(rst), .aes_done_i(aes_done), .aes_result_i(aes_result),
        .wb_addr_i(wb_addr), .mem(mem), .wb_busy_o(wb_busy), .wb_done_o(wb_done),
        .wb_err_o(wb_err), .wb_overrun_o(wb_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One AES block: memory acts with random grant/response delays, every store is
    // compared against the address/data list derived from base and result words.
    task automatic run_block(input logic [31:0] base, input logic [127:0] res,
                             input int gmin, input int gmax, input int rmin, input int rmax,
                             input logic [3:0] errs, input int ovr, input int exp_cyc);
        logic [31:0] ea [4];
        logic [31:0] ed [4];
        int cyc = 0, issued = 0, resp = 0, gwait, rwait = 0;
        bit pend = 0, done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            ea[k] = (base & 32'hFFFF_FFFC) + 32'(4 * k);
            ed[k] = res[32*k +: 32];
        end
        @(negedge clk);
        chk("idle_busy", wb_busy, 0);
        aes_done = 1; aes_result = res; wb_addr = base;
        gwait = $urandom_range(gmax, gmin);
        while (!done_seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            aes_done = 0; mem.data_gnt = 0; mem.data_rvalid = 0; mem.data_err = 0;
            if (cyc == ovr) begin
                aes_done = 1; aes_result = ~res; wb_addr = base ^ 32'h100;
            end
            #1;
            chk("overrun", wb_overrun, cyc == ovr);
            chk("busy", wb_busy, 1);
            if (wb_done) begin
                done_seen = 1;
                chk("done_stores", issued, 4);
                chk("done_resps", resp, 4);
                chk("done_err", wb_err, |errs);
                if (exp_cyc > 0) chk("done_cycle", cyc, exp_cyc);
            end else if (mem.data_req) begin
                chk("two_outstanding", pend, 0);
                chk("store_count_ok", issued < 4, 1);
                chk("req_addr", mem.data_addr, ea[issued & 3]);
                chk("req_data", mem.data_wdata, ed[issued & 3]);
                chk("req_we_be", {mem.data_we, mem.data_be}, 5'h1F);
                if (gwait == 0) begin
                    mem.data_gnt = 1; pend = 1; issued++;
                    rwait = $urandom_range(rmax, rmin);
                    gwait = $urandom_range(gmax, gmin);
                end else begin
                    gwait--;
                    mem.data_rvalid = 1'($urandom_range(1)); mem.data_err = 1;
                end
            end else if (pend) begin
                chk("wait_we_be", {mem.data_we, mem.data_be}, 0);
                mem.data_gnt = 1'($urandom_range(1));
                rwait--;
                if (rwait == 0) begin
                    mem.data_rvalid = 1; mem.data_err = errs[resp]; resp++; pend = 0;
                end
            end
        end
        if (!done_seen) chk("timeout", 0, 1);
        @(negedge clk);
        aes_done = 0; mem.data_gnt = 0; mem.data_rvalid = 0; mem.data_err = 0;
        #1;
        chk("post_done", {wb_done, wb_busy, mem.data_req}, 0);
    endtask

    initial begin
        mem.data_gnt = 0; mem.data_rvalid = 0; mem.data_err = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outputs", {mem.data_req, mem.data_we, mem.data_be, mem.data_addr, mem.data_wdata,
                            wb_busy, wb_done, wb_err, wb_overrun}, 0);
        rst = 0;
        run_block(32'h1000, 128'h33333333_22222222_11111111_00000000, 0, 0, 1, 1, 4'b0000, 0, 9);
        run_block(32'h3000, {$urandom, $urandom, $urandom, $urandom}, 3, 3, 2, 2, 4'b0000, 0, -1);
        run_block(32'h2003, {$urandom, $urandom, $urandom, $urandom}, 0, 2, 1, 3, 4'b0100, 0, -1);
        run_block(32'h5000, 128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000, 0, 0, 1, 1, 4'b0000, 4, 9);
        run_block(32'hFFFF_FFF8, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1, 1, 4'b1000, 9, 9);
        // reset while a store is outstanding
        @(negedge clk);
        aes_done = 1; aes_result = '1; wb_addr = 32'h4000;
        @(negedge clk);
        aes_done = 0; mem.data_gnt = 1;
        @(negedge clk);
        mem.data_gnt = 0;
        #1;
        chk("wait_state", {wb_busy, mem.data_req}, 2'b10);
        #1 rst = 1;
        #1;
        chk("rst_in_wait", {wb_busy, wb_done, wb_err, mem.data_req, mem.data_be}, 0);
        @(negedge clk);
        rst = 0; mem.data_rvalid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem.data_rvalid = 0;
            #1;
            chk("no_done_after_rst", {wb_done, wb_busy, mem.data_req}, 0);
        end
        // reset while a request is pending drops it without a clock edge
        @(negedge clk);
        aes_done = 1; wb_addr = 32'h4400;
        @(negedge clk);
        aes_done = 0;
        #1;
        chk("req_before_rst", mem.data_req, 1);
        #1 rst = 1;
        #1;
        chk("rst_async_req", {mem.data_req, mem.data_we, mem.data_be, wb_busy}, 0);
        @(negedge clk);
        rst = 0;
        run_block(32'h6000, 128'h0123456789ABCDEF_FEDCBA9876543210, 0, 1, 1, 2, 4'b0000, 0, -1);
        for (int i = 0; i < 8; i++)
            run_block($urandom, {$urandom, $urandom, $urandom, $urandom},
                      0, $urandom_range(3), 1, $urandom_range(3) + 1, 4'($urandom),
                      ($urandom_range(3) == 0) ? $urandom_range(12, 1) : 0, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
